card_dealer: RTL
================

# card_dealer

Parametrised card source for the BlackJack datapath. It replaces the plain 1..10 wrap counter with an LFSR-driven dealer that tracks a shoe of NUM_DECKS standard decks, so no card is dealt more often than the shoe holds. It serves draws over a request/valid handshake and supports shuffle (refill), reseed and empty-shoe signalling. It sits between the game-control FSM and the hand-score accumulators.

## Interface
- LFSR_W, 16: LFSR width; fixed polynomial x^16+x^14+x^13+x^11+1 (Galois, tap mask 16'hB400).
- SEED, 16'hACE1: reset and default seed; a value of 0 is replaced by 1.
- NUM_DECKS, 1: decks in the shoe (1..8); 4*NUM_DECKS cards per rank.
- MAX_TRIES, 32: random pick attempts before the scan fallback.

- clk  in  1  clock.
- rst  in  1  reset, asynchronous, active-high.
- draw_req  in  1  request one card; sampled only in IDLE.
- shuffle  in  1  refill the shoe and abort any pending draw.
- reseed  in  1  load the LFSR from seed_in.
- seed_in  in  LFSR_W  seed value; 0 means use SEED.
- card_valid  out  1  one-cycle pulse; card outputs valid.
- card_rank  out  4  1=A, 2..10, 11=J, 12=Q, 13=K; held until the next deal.
- card_value  out  4  score value: A=1, 2..10 as rank, J/Q/K=10; held.
- cards_left  out  clog2(52*NUM_DECKS+1)  cards remaining in the shoe.
- deck_empty  out  1  high when cards_left==0.
- busy  out  1  high in PICK or SCAN.
- draw_err  out  1  one-cycle pulse when draw_req arrives with the shoe empty.

## Operation
- LFSR advances every cycle, except in a reseed cycle, where it loads seed_in (or SEED if seed_in==0).
- Per-rank counters (13 entries, width clog2(4*NUM_DECKS+1)) reset/refill to 4*NUM_DECKS.
- FSM states: IDLE, PICK, SCAN.
- IDLE:
  - draw_req && !deck_empty -> PICK, try counter cleared.
  - draw_req && deck_empty -> draw_err pulse next cycle, stay IDLE.
- PICK: candidate rank is r = lfsr[3:0] + 1.
  - Hit when lfsr[3:0] < 13 and count[r] > 0: decrement count[r], load card_rank/card_value, pulse card_valid next cycle, decrement cards_left, -> IDLE.
  - Miss: try counter +1, stay PICK.
  - After MAX_TRIES misses -> SCAN with pointer at rank 1.
- SCAN: if count[ptr] > 0, deal ptr as in a PICK hit and -> IDLE; else ptr+1. A non-empty shoe guarantees a hit within 13 cycles.
- shuffle (any state):
  - Counters refill, cards_left = 52*NUM_DECKS, FSM -> IDLE.
  - No card_valid is produced for an aborted draw.
  - shuffle has priority over draw_req and over a same-cycle hit.
  - Applies on the next edge.
- reseed and shuffle are independent and may occur together.
- Reset state:
  - lfsr=SEED and counters full.
  - cards_left=52*NUM_DECKS, FSM=IDLE.
  - card_valid=0, card_rank=0, card_value=0.
  - deck_empty=0, busy=0, draw_err=0.

## Timing
- All outputs are registered.
- Edge-by-edge, best case:
  - Edge 0: draw_req sampled in IDLE.
  - Edge 1: PICK hit evaluated.
  - Edge 2: card_valid high for one cycle.
- Worst case: card_valid at edge MAX_TRIES+13+1.
- The FSM is IDLE during the card_valid cycle, so a held draw_req is accepted immediately. Peak throughput is 1 card per 2 cycles.
- cards_left and deck_empty update in the same cycle card_valid rises.
- draw_err rises 1 cycle after the rejected request.
- busy is high from the cycle after acceptance until the card_valid cycle, exclusive of that cycle.
- Reset mid-draw: outputs return to reset values immediately, with no card_valid.

## Test plan
- Reset, then idle 10 cycles -> card_valid=0, card_rank=0, card_value=0, cards_left=52, deck_empty=0, busy=0.
- Single draw_req pulse -> exactly one card_valid after 2..46 cycles; card_rank in 1..13; card_value equals min(rank,10); cards_left=51.
- draw_req held for 52 deals -> each rank seen exactly 4 times, deck_empty=1 after the 52nd card. A 53rd request -> draw_err pulse, no card_valid, cards_left stays 0.
- shuffle asserted in a PICK/SCAN cycle -> no card_valid for that draw, cards_left=52 next cycle, busy=0.
- reseed with seed_in=0 -> LFSR loads 16'hACE1 and the card sequence matches the post-reset sequence. With seed_in=16'h1234, the dealt sequence is repeatable across two runs.
- NUM_DECKS=2: deal 103 cards, leaving a single rank -> final draw completes via SCAN within MAX_TRIES+14 cycles. Totals per rank are 8, and cards_left=0 at the end.

Source files
------------

// File: rtl/card_dealer.sv
// card_dealer: LFSR-driven card source that tracks a shoe of NUM_DECKS decks.
// Deals one card per request/valid handshake; supports shuffle, reseed and empty-shoe errors.
module card_dealer #(
  parameter int                LFSR_W    = 16,
  parameter logic [LFSR_W-1:0] SEED      = 16'hACE1,
  parameter int                NUM_DECKS = 1,
  parameter int                MAX_TRIES = 32
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic                               draw_req_i,
  input  logic                               shuffle_i,
  input  logic                               reseed_i,
  input  logic [LFSR_W-1:0]                  seed_in_i,
  output logic                               card_valid_o,
  output logic [3:0]                         card_rank_o,
  output logic [3:0]                         card_value_o,
  output logic [$clog2(52*NUM_DECKS+1)-1:0]  cards_left_o,
  output logic                               deck_empty_o,
  output logic                               busy_o,
  output logic                               draw_err_o
);

  localparam int CL_W = $clog2(52*NUM_DECKS+1);
  localparam int RC_W = $clog2(4*NUM_DECKS+1);
  localparam int TR_W = $clog2(MAX_TRIES+1);
  localparam logic [LFSR_W-1:0] TAPS      = LFSR_W'(16'hB400);
  localparam logic [LFSR_W-1:0] SEED_NZ   = (SEED == '0) ? LFSR_W'(1) : SEED;
  localparam logic [RC_W-1:0]   RANK_FULL = RC_W'(4*NUM_DECKS);
  localparam logic [CL_W-1:0]   SHOE_FULL = CL_W'(52*NUM_DECKS);

  // IDLE | waiting for draw_req
  // PICK | random rank attempts driven by the LFSR
  // SCAN | linear search for the first rank with cards left
  typedef enum logic [1:0] {IDLE, PICK, SCAN} state_t;

  state_t            state_q, state_d;
  logic [LFSR_W-1:0] lfsr_q, lfsr_d, lfsr_step;
  logic [TR_W-1:0]   tries_q, tries_d;
  logic [3:0]        ptr_q, ptr_d;
  logic [RC_W-1:0]   cnt_q [13];
  logic [RC_W-1:0]   cnt_d [13];
  logic [CL_W-1:0]   left_q, left_d;
  logic [3:0]        rank_q, rank_d, value_q, value_d;
  logic              valid_q, valid_d, err_q, err_d, empty_q, empty_d;
  logic              deal;
  logic [3:0]        deal_idx, pick_idx;

  assign lfsr_step = {1'b0, lfsr_q[LFSR_W-1:1]} ^ (lfsr_q[0] ? TAPS : '0);
  assign pick_idx  = lfsr_q[3:0];

  always_comb begin
    state_d  = state_q;
    tries_d  = tries_q;
    ptr_d    = ptr_q;
    cnt_d    = cnt_q;
    left_d   = left_q;
    rank_d   = rank_q;
    value_d  = value_q;
    valid_d  = 1'b0;
    err_d    = 1'b0;
    deal     = 1'b0;
    deal_idx = '0;
    lfsr_d   = lfsr_step;
    if (reseed_i) begin
      lfsr_d = (seed_in_i == '0) ? SEED_NZ : seed_in_i;
    end

    case (state_q)
      IDLE: begin
        if (draw_req_i) begin
          if (left_q == '0) begin
            err_d = 1'b1;
          end else begin
            state_d = PICK;
            tries_d = '0;
          end
        end
      end
      PICK: begin
        if ((pick_idx < 4'd13) && (cnt_q[pick_idx] != '0)) begin
          deal     = 1'b1;
          deal_idx = pick_idx;
        end else if (tries_q == TR_W'(MAX_TRIES-1)) begin
          state_d = SCAN;
          ptr_d   = '0;
        end else begin
          tries_d = tries_q + TR_W'(1);
        end
      end
      SCAN: begin
        if (cnt_q[ptr_q] != '0) begin
          deal     = 1'b1;
          deal_idx = ptr_q;
        end else begin
          ptr_d = (ptr_q == 4'd12) ? 4'd0 : ptr_q + 4'd1;
        end
      end
      default: state_d = IDLE;
    endcase

    if (deal) begin
      cnt_d[deal_idx] = cnt_q[deal_idx] - RC_W'(1);
      left_d          = left_q - CL_W'(1);
      rank_d          = deal_idx + 4'd1;
      value_d         = (deal_idx >= 4'd10) ? 4'd10 : deal_idx + 4'd1;
      valid_d         = 1'b1;
      state_d         = IDLE;
    end

    // Shuffle wins over any request or same-cycle deal; the last card stays on the outputs.
    if (shuffle_i) begin
      cnt_d   = '{default: RANK_FULL};
      left_d  = SHOE_FULL;
      state_d = IDLE;
      rank_d  = rank_q;
      value_d = value_q;
      valid_d = 1'b0;
      err_d   = 1'b0;
    end

    empty_d = (left_d == '0);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      lfsr_q  <= SEED_NZ;
      tries_q <= '0;
      ptr_q   <= '0;
      cnt_q   <= '{default: RANK_FULL};
      left_q  <= SHOE_FULL;
      rank_q  <= '0;
      value_q <= '0;
      valid_q <= 1'b0;
      err_q   <= 1'b0;
      empty_q <= 1'b0;
    end else begin
      state_q <= state_d;
      lfsr_q  <= lfsr_d;
      tries_q <= tries_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
      left_q  <= left_d;
      rank_q  <= rank_d;
      value_q <= value_d;
      valid_q <= valid_d;
      err_q   <= err_d;
      empty_q <= empty_d;
    end
  end

  assign card_valid_o = valid_q;
  assign card_rank_o  = rank_q;
  assign card_value_o = value_q;
  assign cards_left_o = left_q;
  assign deck_empty_o = empty_q;
  assign busy_o       = (state_q != IDLE);
  assign draw_err_o   = err_q;

endmodule
